// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// default memory map constants and the maximum frame length derivation.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;
  localparam int unsigned DEF_MEM_BYTES = 65536;
  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;

  // Largest word count that still fits between the base address and the end
  // of memory; saturates at the 16-bit header range.
  function automatic logic [15:0] calc_maxw(input logic [31:0] base,
                                            input int unsigned mem_bytes);
    logic [31:0] words;
    words = (mem_bytes - base) >> 2;
    return (words > 32'h0000_FFFF) ? 16'hFFFF : words[15:0];
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_valid is a
// combinational strobe on the byte that completes a word.
module imem_boot_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] lanes_q, lanes_d;

  always_comb begin
    lane_d  = lane_q;
    lanes_d = lanes_q;
    if (clr) begin
      lane_d  = 2'd0;
      lanes_d = 24'd0;
    end else if (byte_valid) begin
      case (lane_q)
        2'd0:    lanes_d[7:0]   = byte_data;
        2'd1:    lanes_d[15:8]  = byte_data;
        2'd2:    lanes_d[23:16] = byte_data;
        default: lanes_d        = lanes_q;
      endcase
      lane_d = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q  <= 2'd0;
      lanes_q <= 24'd0;
    end else begin
      lane_q  <= lane_d;
      lanes_q <= lanes_d;
    end
  end

  // The top lane is never stored: it arrives with the completing byte.
  assign word_valid = byte_valid && !clr && (lane_q == 2'd3);
  assign word       = {byte_data, lanes_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a framed byte stream, writes packed words into
// instruction memory and releases the core after a good checksum.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);

  localparam logic [15:0] MAXW = calc_maxw(BASE_ADDR, MEM_BYTES);

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] word_count_q, word_count_d;
  logic [7:0]  csum_q, csum_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic [15:0] hdr_n;
  logic        pk_clr;
  logic        pk_byte_valid;
  logic        pk_word_valid;
  logic [31:0] pk_word;

  assign accept        = in_valid && in_ready;
  assign hdr_n         = {in_data, n_q[7:0]};
  assign pk_clr        = (state_q != ST_DATA);
  assign pk_byte_valid = accept && (state_q == ST_DATA);

  imem_boot_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_valid (pk_byte_valid),
    .byte_data  (in_data),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_count_d = word_count_q;
    csum_d       = csum_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    // Write port is registered so the pulse lands one cycle after lane 3.
    if (pk_word_valid) begin
      mem_we_d     = 1'b1;
      mem_wdata_d  = pk_word;
      mem_addr_d   = BASE_ADDR + {14'd0, word_count_q, 2'b00};
      word_count_d = word_count_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d      = ST_HDR0;
          word_count_d = 16'd0;
          csum_d       = 8'd0;
        end
      end
      ST_HDR0: begin
        if (accept) begin
          n_d[7:0] = in_data;
          state_d  = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (accept) begin
          n_d[15:8] = in_data;
          if (hdr_n > MAXW)       state_d = ST_ERR;
          else if (hdr_n == 16'd0) state_d = ST_CSUM;
          else                    state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          if (pk_word_valid && ((word_count_q + 16'd1) == n_q)) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (reload) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_q          <= 16'd0;
      word_count_q <= 16'd0;
      csum_q       <= 8'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_count_q <= word_count_d;
      csum_q       <= csum_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Status outputs decode straight from the state register.
  assign in_ready   = (state_q != ST_DONE) && (state_q != ST_ERR);
  assign busy       = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign cpu_rst    = (state_q != ST_DONE);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames from the test plan
// plus randomized frames checked against a frame-level reference model.
module tb_imem_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [15:0] MAXW = 16'd15360;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  imem_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Observed writes, captured away from the rising edge.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [15:0] wr_wc[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_wc.push_back(word_count);
    end
  end

  logic [31:0] fw[$];
  logic [7:0]  garb[$];

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (in_ready === 1'b1) break;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", 32'(in_ready), 32'd1);
    else @(posedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_addr"},   mem_addr,        BASE);
    check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    check({tag, "_cpu_rst"},    32'(cpu_rst),    32'd1);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
    check({tag, "_in_ready"},   32'(in_ready),   32'd1);
  endtask

  // Reference: a frame with header n either loads fw[] at consecutive words
  // from BASE (n in range) or aborts before any write (n > MAXW).
  task automatic run_frame(input string tag, input logic [15:0] n_hdr, input bit bad, input bit gaps);
    logic [7:0] cs;
    logic [7:0] b;
    bit         hdr_bad;
    bit         exp_err;
    int         exp_n;
    hdr_bad = (n_hdr > MAXW);
    exp_err = hdr_bad || bad;
    exp_n   = hdr_bad ? 0 : fw.size();
    wr_addr.delete();
    wr_data.delete();
    wr_wc.delete();
    foreach (garb[i]) send_byte(garb[i], gaps);
    send_byte(8'hA5, gaps);
    send_byte(n_hdr[7:0], gaps);
    send_byte(n_hdr[15:8], gaps);
    cs = 8'd0;
    if (!hdr_bad) begin
      foreach (fw[i]) begin
        for (int k = 0; k < 4; k++) begin
          b  = fw[i][8*k +: 8];
          cs = cs ^ b;
          send_byte(b, gaps);
        end
      end
      send_byte(bad ? (cs ^ 8'h01) : cs, gaps);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
      check({tag, "_addr"},  wr_addr[i],     BASE + 32'(4 * i));
      check({tag, "_data"},  wr_data[i],     fw[i]);
      check({tag, "_wr_wc"}, 32'(wr_wc[i]),  32'(i + 1));
    end
    check({tag, "_done"},       32'(done),       32'(!exp_err));
    check({tag, "_err"},        32'(err),        32'(exp_err));
    check({tag, "_cpu_rst"},    32'(cpu_rst),    32'(exp_err));
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'(exp_n));
  endtask

  task automatic pulse_reload(input string tag);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check({tag, "_rl_err"},      32'(err),      32'd0);
    check({tag, "_rl_done"},     32'(done),     32'd0);
    check({tag, "_rl_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_rl_cpu_rst"},  32'(cpu_rst),  32'd1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] g;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    reload   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;

    fw = '{32'hFFC4A303, 32'h0064A423, 32'h0062E233, 32'hFDA48393, 32'hFE420AE3};
    run_frame("t1_good", 16'd5, 1'b0, 1'b0);
    pulse_reload("t1");

    run_frame("t2_badcs", 16'd5, 1'b1, 1'b0);
    pulse_reload("t2");

    garb = '{8'h00, 8'hFF, 8'h5A};
    fw   = '{32'h0000_0013};
    run_frame("t3_garbage", 16'd1, 1'b0, 1'b0);
    pulse_reload("t3");
    garb.delete();

    fw.delete();
    run_frame("t4_toolong", 16'h3C01, 1'b0, 1'b0);
    pulse_reload("t4");

    run_frame("t5_empty", 16'd0, 1'b0, 1'b0);
    pulse_reload("t5");

    // Header at exactly the limit must be accepted and enter the payload phase.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h3C, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("maxw_busy",     32'(busy),     32'd1);
    check("maxw_err",      32'(err),      32'd0);
    check("maxw_in_ready", 32'(in_ready), 32'd1);
    do_reset("maxw_rst");

    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("t6_mid_busy", 32'(busy), 32'd1);
    do_reset("t6_rst");
    fw = '{32'($urandom), 32'($urandom)};
    run_frame("t6_after", 16'd2, 1'b0, 1'b1);
    pulse_reload("t6");

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 6);
      fw.delete();
      garb.delete();
      for (int i = 0; i < n; i++) fw.push_back($urandom);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        do g = 8'($urandom); while (g == 8'hA5);
        garb.push_back(g);
      end
      run_frame("rnd", 16'(n), ($urandom_range(0, 3) == 0), 1'b1);
      pulse_reload("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot-time controller that fills instruction memory from a byte stream (UART or debug bridge) before the single-cycle core runs.
- Holds the core in reset, parses a framed byte stream and packs bytes little-endian into 32-bit words.
- Issues one write per word to the instruction memory write port at consecutive byte addresses from BASE_ADDR.
- Releases the core only after a checksum-verified load.

Parameters:
BASE_ADDR, 32'h00001000, byte address of the first word written; also the core's reset PC.
MEM_BYTES, 65536, instruction memory size in bytes.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  byte stream valid
in_data  in  8  byte stream data
in_ready  out  1  loader can accept a byte; a byte transfers when in_valid & in_ready on a rising edge
reload  in  1  single-cycle pulse; re-arm the loader from DONE or ERR
mem_we  out  1  instruction memory write strobe, one cycle per word
mem_addr  out  32  byte address of the word being written (word aligned)
mem_wdata  out  32  word data; byte at mem_addr is mem_wdata[7:0]
cpu_rst  out  1  core reset; high while loading or after an error
busy  out  1  a frame is in progress (states HDR0..CSUM)
done  out  1  load completed with good checksum
err  out  1  load aborted (bad checksum or size overflow)
word_count  out  16  number of words written in the current or last frame

Behaviour:
- Reset (async): state=IDLE; in_ready=1; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; cpu_rst=1; busy=0; done=0; err=0; word_count=0. Reset mid-frame discards all partial state.
- Frame format: SYNC_BYTE, N[7:0], N[15:8], then 4*N payload bytes, then CSUM = XOR of all payload bytes (8 bits).
- MAXW = (MEM_BYTES - BASE_ADDR)/4, i.e. 15360 at defaults.
- IDLE: accept every byte. A byte equal to SYNC_BYTE goes to HDR0 and clears word_count and the checksum accumulator. Other bytes are discarded.
- HDR0: latch N low byte, go to HDR1.
- HDR1: latch N high byte.
  - N > MAXW: go to ERR.
  - N == 0: go to CSUM.
  - otherwise: go to DATA, byte index = 0.
- DATA: each accepted byte goes into lane [index] of a shift/pack register and is XORed into the checksum. On lane 3:
  - next cycle, mem_we=1 (one cycle), mem_wdata = packed word, mem_addr = BASE_ADDR + 4*word_count;
  - word_count increments in that same write cycle.
  - After the Nth word is accepted, go to CSUM.
  - in_ready stays high through writes; the write is a registered pulse, so back-to-back bytes are sustained at one per cycle.
- CSUM: compare the accepted byte with the accumulator.
  - Equal: go to DONE.
  - Else: go to ERR.
  - The final word's mem_we pulse may coincide with the CSUM byte-accept cycle; this is legal.
- DONE: done=1, cpu_rst=0, in_ready=0, busy=0.
- ERR: err=1, cpu_rst=1, in_ready=0, busy=0.
- reload in DONE or ERR: the next cycle is IDLE with cpu_rst=1, done=0, err=0, in_ready=1. reload in any other state is ignored.
- cpu_rst falls in the same cycle done rises. Both are registered, with no combinational path from in_* to any output except in_ready, which is decoded from state only.
- mem_addr never exceeds MEM_BYTES-4, guaranteed by the N check.

Decomposition:
- Shared loader header/package: state encoding (IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR), SYNC_BYTE default, MAXW derivation, memory size constants shared with instruction memory.
- Sub-module byte_packer: 2-bit lane counter, 32-bit little-endian assembly, word_valid pulse on the 4th byte, synchronous clear input.
- The top level holds the FSM, counters, checksum and write-port registers.

Test Plan:
1. Load words FFC4A303, 0064A423, 0062E233, FDA48393, FE420AE3.
   - Stimulus: A5 05 00 + 20 payload bytes LSB-first (03 A3 C4 FF ...) + correct XOR.
   - Expect: 5 mem_we pulses at 0x1000, 0x1004, 0x1008, 0x100C, 0x1010 with those exact words; word_count=5; done=1; cpu_rst=0.
2. Same frame with the checksum byte XORed with 0x01.
   - Expect: all 5 writes occur; err=1; cpu_rst stays 1; in_ready=0.
   - Then a reload pulse returns to IDLE with err=0.
3. Garbage bytes 00 FF 5A before A5 01 00 + 13 00 00 00 + 13.
   - Expect: garbage ignored; a single write of 0x00000013 at 0x1000; done=1.
4. Header N=0x3C01 (15361).
   - Expect: ERR immediately after the 3rd byte; zero mem_we pulses.
5. Header N=0 followed by CSUM 00.
   - Expect: done=1, word_count=0, no writes.
6. rst asserted mid-DATA, after 6 payload bytes.
   - Expect: asynchronous return to reset values, cpu_rst=1.
   - A subsequent valid frame loads correctly from 0x1000.
